fetch_queue_unit: RTL and testbench

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

---
 rtl/fetch_queue_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction fetch front end: owns the PC, issues single-cycle-latency
// instruction memory reads, and buffers the returned instructions in a small
// FIFO that the decode stage drains with a valid/ready handshake.
//
// Fetch issue is credit based: a request is only issued if the entry it will
// produce is guaranteed a slot, counting queued entries, the outstanding
// request and the entry being popped this cycle.  This keeps one instruction
// per cycle of sustained throughput without ever overflowing the queue.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   imem_req     out  instruction memory read request this cycle
//   imem_addr    out  fetch address (the PC register)
//   imem_rdata   in   read data, valid one cycle after imem_req
//   redirect     in   taken branch/jump: flush queue and reload PC
//   redirect_pc  in   new PC (bits [1:0] forced to zero)
//   halt         in   suppress new requests (outstanding one still lands)
//   out_valid    out  head entry available
//   out_ready    in   decode accepts head entry
//   out_pc       out  PC of head entry (0 when empty)
//   out_instr    out  instruction of head entry (0 when empty)
//   fq_count     out  queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [PC_W-1:0]               imem_addr,
    input  logic [INS_W-1:0]              imem_rdata,
    input  logic                          redirect,
    input  logic [PC_W-1:0]               redirect_pc,
    input  logic                          halt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_W-1:0]               out_pc,
    output logic [INS_W-1:0]              out_instr,
    output logic [$clog2(FQ_DEPTH):0]     fq_count
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(3'd4);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W+1)'(FQ_DEPTH);

    // Architectural state
    logic [PC_W-1:0]  r_pc;
    logic             r_inflight;
    logic [PC_W-1:0]  r_pending_pc;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  r_mem_pc  [FQ_DEPTH];
    logic [INS_W-1:0] r_mem_ins [FQ_DEPTH];

    // Combinational control
    logic             w_not_empty;
    logic             w_full;
    logic             w_out_valid;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W:0]   w_occ;
    logic             w_req;
    logic [PC_W-1:0]  w_redirect_pc;

    // Handshake, credit check and request decision for this cycle
    always_comb begin
        w_not_empty   = (r_count != {CNT_W{1'b0}});
        w_full        = (r_count == DEPTH_CNT);
        w_out_valid   = w_not_empty & ~redirect;
        w_pop         = w_out_valid & out_ready;
        w_redirect_pc = {redirect_pc[PC_W-1:2], 2'b00};

        // Occupancy the queue would have if the outstanding request landed
        // and the current pop happened; a new request needs one more slot.
        // pop implies count >= 1, so the subtraction cannot underflow.
        w_occ = {1'b0, r_count}
              + {{CNT_W{1'b0}}, r_inflight}
              - {{CNT_W{1'b0}}, w_pop};

        if (reset && !halt && !redirect && (w_occ < DEPTH_OCC)) begin
            w_req = 1'b1;
        end else begin
            w_req = 1'b0;
        end

        // Returning data is written unless a redirect discards it.  The full
        // guard only matters if the credit rule were ever violated; the entry
        // is then dropped rather than overwriting live data.
        if (r_inflight && !redirect && (!w_full || w_pop)) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // PC, outstanding-request tracking, queue pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_inflight   <= 1'b0;
            r_pending_pc <= {PC_W{1'b0}};
            r_wptr       <= {PTR_W{1'b0}};
            r_rptr       <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
        end else if (redirect) begin
            // Flush: anything queued or returning next cycle is wrong-path
            r_pc         <= w_redirect_pc;
            r_inflight   <= 1'b0;
            r_wptr       <= {PTR_W{1'b0}};
            r_rptr       <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
        end else begin
            if (w_req) begin
                r_pc         <= r_pc + PC_STEP;
                r_pending_pc <= r_pc;
            end
            r_inflight <= w_req;

            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1'b1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage: write the returning instruction with its fetch PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_mem_pc[i]  <= {PC_W{1'b0}};
                r_mem_ins[i] <= {INS_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem_pc[r_wptr]  <= r_pending_pc;
            r_mem_ins[r_wptr] <= imem_rdata;
        end
    end

    // Output drive; head fields read as zero while the queue is empty
    always_comb begin
        imem_req  = w_req;
        imem_addr = r_pc;
        out_valid = w_out_valid;
        fq_count  = r_count;
        if (w_not_empty) begin
            out_pc    = r_mem_pc[r_rptr];
            out_instr = r_mem_ins[r_rptr];
        end else begin
            out_pc    = {PC_W{1'b0}};
            out_instr = {INS_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// Directed bench. A vector table drives the default (depth 4) instance through
// reset, streaming, backpressure, redirect, halt, halt+redirect and PC wrap.
// Hand-written sequences cover asynchronous reset between edges and queue
// pointer wrap on a depth-2 instance under alternating out_ready.
// Instruction memory model returns tag(addr) one cycle after each request.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [8:0] a);
        return {16'hC0DE, 7'h00, a};
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- default instance (depth 4) ----------------
    logic        reset = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [8:0]  redirect_pc = 9'h000;
    logic        out_ready = 1'b0;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
    logic [2:0]  fq_count;

    fetch_queue_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .fq_count(fq_count)
    );

    always @(posedge clk) if (imem_req) imem_rdata <= tag(imem_addr);

    // ---------------- depth-2 instance ----------------
    logic        b_reset = 1'b0;
    logic        b_halt = 1'b0;
    logic        b_redirect = 1'b0;
    logic [8:0]  b_redirect_pc = 9'h000;
    logic        b_out_ready = 1'b0;
    logic        b_imem_req;
    logic [8:0]  b_imem_addr;
    logic [31:0] b_imem_rdata = 32'h0;
    logic        b_out_valid;
    logic [8:0]  b_out_pc;
    logic [31:0] b_out_instr;
    logic [1:0]  b_fq_count;

    fetch_queue_unit #(.PC_W(9), .INS_W(32), .FQ_DEPTH(2), .RESET_PC(9'h000)) dut2 (
        .clk(clk), .reset(b_reset), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_rdata(b_imem_rdata), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
        .halt(b_halt), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_instr(b_out_instr), .fq_count(b_fq_count)
    );

    always @(posedge clk) if (b_imem_req) b_imem_rdata <= tag(b_imem_addr);

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       hlt;
        logic       rdr;
        logic [8:0] rpc;
        logic       rdy;
        logic       e_req;
        logic [8:0] e_addr;
        logic       e_val;
        logic [8:0] e_opc;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tv[$];

    task automatic v(input logic rst, input logic hlt, input logic rdr, input logic [8:0] rpc,
                     input logic rdy, input logic e_req, input logic [8:0] e_addr,
                     input logic e_val, input logic [8:0] e_opc, input logic [2:0] e_cnt);
        vec_t t;
        t.rst = rst; t.hlt = hlt; t.rdr = rdr; t.rpc = rpc; t.rdy = rdy;
        t.e_req = e_req; t.e_addr = e_addr; t.e_val = e_val; t.e_opc = e_opc; t.e_cnt = e_cnt;
        tv.push_back(t);
    endtask

    initial begin
        logic [8:0]  exp_pc;
        logic [31:0] exp_ins;
        int          pops;

        //  rst hlt rdr rpc     rdy | req addr    val opc     cnt
        v(1'b0,1'b0,1'b0,9'h000,1'b1, 1'b0,9'h000,1'b0,9'h000,3'd0); // reset
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h000,1'b0,9'h000,3'd0); // stream
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h004,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h008,1'b1,9'h000,3'd1);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h00C,1'b1,9'h004,3'd1);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h010,1'b1,9'h008,3'd1);
        v(1'b0,1'b0,1'b0,9'h000,1'b1, 1'b0,9'h000,1'b0,9'h000,3'd0); // reset again
        v(1'b0,1'b0,1'b0,9'h000,1'b1, 1'b0,9'h000,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b0, 1'b1,9'h000,1'b0,9'h000,3'd0); // backpressure x10
        v(1'b1,1'b0,1'b0,9'h000,1'b0, 1'b1,9'h004,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b0, 1'b1,9'h008,1'b1,9'h000,3'd1);
        v(1'b1,1'b0,1'b0,9'h000,1'b0, 1'b1,9'h00C,1'b1,9'h000,3'd2);
        v(1'b1,1'b0,1'b0,9'h000,1'b0, 1'b0,9'h010,1'b1,9'h000,3'd3);
        for (int k = 0; k < 5; k++)
            v(1'b1,1'b0,1'b0,9'h000,1'b0, 1'b0,9'h010,1'b1,9'h000,3'd4);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h010,1'b1,9'h000,3'd4); // drain
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h014,1'b1,9'h004,3'd3);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h018,1'b1,9'h008,3'd3);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h01C,1'b1,9'h00C,3'd3);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h020,1'b1,9'h010,3'd3);
        v(1'b1,1'b0,1'b1,9'h0A3,1'b1, 1'b0,9'h024,1'b0,9'h014,3'd3); // redirect
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h0A0,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h0A4,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h0A8,1'b1,9'h0A0,3'd1);
        v(1'b1,1'b1,1'b0,9'h000,1'b1, 1'b0,9'h0AC,1'b1,9'h0A4,3'd1); // halt
        v(1'b1,1'b1,1'b0,9'h000,1'b1, 1'b0,9'h0AC,1'b1,9'h0A8,3'd1);
        v(1'b1,1'b1,1'b0,9'h000,1'b1, 1'b0,9'h0AC,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h0AC,1'b0,9'h000,3'd0); // resume
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h0B0,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h0B4,1'b1,9'h0AC,3'd1);
        v(1'b1,1'b1,1'b1,9'h1FE,1'b1, 1'b0,9'h0B8,1'b0,9'h0B0,3'd1); // halt+redirect
        v(1'b1,1'b1,1'b0,9'h000,1'b1, 1'b0,9'h1FC,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h1FC,1'b0,9'h000,3'd0); // PC wrap
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h000,1'b0,9'h000,3'd0);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h004,1'b1,9'h1FC,3'd1);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h008,1'b1,9'h000,3'd1);
        v(1'b1,1'b0,1'b0,9'h000,1'b1, 1'b1,9'h00C,1'b1,9'h004,3'd1);

        foreach (tv[i]) begin
            @(negedge clk);
            reset = tv[i].rst; halt = tv[i].hlt; redirect = tv[i].rdr;
            redirect_pc = tv[i].rpc; out_ready = tv[i].rdy;
            #1;
            exp_ins = (tv[i].e_cnt != 3'd0) ? tag(tv[i].e_opc) : 32'h0;
            chk($sformatf("row%0d imem_req", i),  32'(imem_req),  32'(tv[i].e_req));
            chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(tv[i].e_addr));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tv[i].e_val));
            chk($sformatf("row%0d out_pc", i),    32'(out_pc),    32'(tv[i].e_opc));
            chk($sformatf("row%0d out_instr", i), out_instr,      exp_ins);
            chk($sformatf("row%0d fq_count", i),  32'(fq_count),  32'(tv[i].e_cnt));
        end
        redirect = 1'b0; halt = 1'b0;

        // ---- async reset between clock edges ----
        @(posedge clk);
        #2;
        chk("async pre out_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async imem_req",  32'(imem_req),  32'd0);
        chk("async fq_count",  32'(fq_count),  32'd0);
        chk("async out_pc",    32'(out_pc),    32'd0);
        chk("async imem_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("restart imem_req",  32'(imem_req),  32'd1);
        chk("restart imem_addr", 32'(imem_addr), 32'h000);
        @(negedge clk);
        #1;
        chk("restart addr2", 32'(imem_addr), 32'h004);

        // ---- depth-2 pointer wrap, PC wrap, alternating out_ready ----
        @(negedge clk);
        b_reset = 1'b1; b_redirect = 1'b1; b_redirect_pc = 9'h1FC; b_out_ready = 1'b0;
        #1;
        chk("d2 redirect out_valid", 32'(b_out_valid), 32'd0);
        chk("d2 redirect imem_req",  32'(b_imem_req),  32'd0);
        exp_pc = 9'h1FC;
        pops = 0;
        for (int c = 0; c < 80 && pops < 10; c++) begin
            @(negedge clk);
            b_redirect = 1'b0;
            b_out_ready = c[0];
            #1;
            if (c == 0) chk("d2 first addr", 32'(b_imem_addr), 32'h1FC);
            chk($sformatf("d2 cyc%0d count<=2", c), 32'(b_fq_count <= 2'd2), 32'd1);
            if (b_out_valid && b_out_ready) begin
                chk($sformatf("d2 pop%0d pc", pops),    32'(b_out_pc), 32'(exp_pc));
                chk($sformatf("d2 pop%0d instr", pops), b_out_instr,   tag(exp_pc));
                exp_pc = exp_pc + 9'd4;
                pops++;
            end
        end
        chk("d2 pop count", 32'(pops), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
